mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 208 ++++++++++++++++++++
 tb/tb_mdu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu -- multiply/divide unit holding the architectural HI/LO registers.
//
// A multi-cycle op computes its result right away into pending registers.
// busy then holds for MUL_LAT or DIV_LAT cycles, and HI/LO take the pending
// value on the edge that returns the FSM to IDLE.
//
// Optional feature: define MDU_MSUB_EN to enable MSUB (mdop 0111):
// {HI,LO} - signed(inA)*signed(inB). Without the macro, 0111 is a no-op and
// no MSUB datapath is built.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous active-high reset
//   start  in   1   one-cycle op-issue strobe
//   mdop   in   4   operation select (NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MSUB)
//   inA    in  32   rs operand
//   inB    in  32   rt operand
//   busy   out  1   high while a multi-cycle op is in flight
//   HI     out 32   architectural HI
//   LO     out 32   architectural LO
module mdu #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW      = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MSUB  = 4'd7
    } op_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;

    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_pend_hi;
    logic [31:0]     r_pend_lo;
    logic            r_pend_we;

    logic            w_issue;
    logic            w_is_mul;
    logic            w_is_div;
    logic            w_done;

    logic [63:0]     w_a_sx;
    logic [63:0]     w_b_sx;
    logic [63:0]     w_prod_s;
    logic [63:0]     w_prod_u;
    logic [63:0]     w_mul_res;

    logic            w_div_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [31:0]     w_mag_a;
    logic [31:0]     w_mag_b;
    logic [31:0]     w_divisor;
    logic [31:0]     w_uq;
    logic [31:0]     w_ur;
    logic [31:0]     w_quot;
    logic [31:0]     w_rem;
    logic            w_div_zero;

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = (r_state != S_IDLE);

    // Starts arriving while busy are dropped here, protecting the in-flight op.
    assign w_issue = start && (r_state == S_IDLE);

`ifdef MDU_MSUB_EN
    assign w_is_mul = (mdop == OP_MULT) || (mdop == OP_MULTU) || (mdop == OP_MSUB);
`else
    assign w_is_mul = (mdop == OP_MULT) || (mdop == OP_MULTU);
`endif
    assign w_is_div = (mdop == OP_DIV) || (mdop == OP_DIVU);
    assign w_done   = (r_state != S_IDLE) && (r_cnt == CW'(1));

    // ---------------- multiply ----------------
    // Sign-extended 64x64 multiply keeps the low 64 bits of the true signed product.
    assign w_a_sx   = {{32{inA[31]}}, inA};
    assign w_b_sx   = {{32{inB[31]}}, inB};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'b0, inA} * {32'b0, inB};

    always_comb begin
        w_mul_res = w_prod_s;
        if (mdop == OP_MULTU) begin
            w_mul_res = w_prod_u;
        end
`ifdef MDU_MSUB_EN
        if (mdop == OP_MSUB) begin
            w_mul_res = {r_hi, r_lo} - w_prod_s;
        end
`endif
    end

    // ---------------- divide ----------------
    // Signed divide runs on magnitudes and fixes signs afterwards. The
    // 0x80000000 / -1 case falls out naturally: the magnitude 2^31 fits in
    // 32 unsigned bits, and negating it wraps back to 0x80000000.
    assign w_div_signed = (mdop == OP_DIV);
    assign w_neg_a      = w_div_signed && inA[31];
    assign w_neg_b      = w_div_signed && inB[31];
    assign w_mag_a      = w_neg_a ? (-inA) : inA;
    assign w_mag_b      = w_neg_b ? (-inB) : inB;
    assign w_div_zero   = (inB == '0);
    // Substitute divisor keeps the datapath defined; the result is discarded.
    assign w_divisor    = w_div_zero ? 32'd1 : w_mag_b;
    assign w_uq         = w_mag_a / w_divisor;
    assign w_ur         = w_mag_a % w_divisor;
    assign w_quot       = (w_neg_a ^ w_neg_b) ? (-w_uq) : w_uq;
    assign w_rem        = w_neg_a ? (-w_ur) : w_ur;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_issue && w_is_mul) begin
                    w_state_next = S_MUL;
                    w_cnt_next   = CW'(MUL_LAT);
                end else if (w_issue && w_is_div) begin
                    w_state_next = S_DIV;
                    w_cnt_next   = CW'(DIV_LAT);
                end
            end
            S_MUL, S_DIV: begin
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ---------------- pending / architectural registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_we <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_issue && w_is_mul) begin
                r_pend_hi <= w_mul_res[63:32];
                r_pend_lo <= w_mul_res[31:0];
                r_pend_we <= 1'b1;
            end else if (w_issue && w_is_div) begin
                r_pend_hi <= w_rem;
                r_pend_lo <= w_quot;
                // Divide by zero runs the full latency but commits nothing.
                r_pend_we <= !w_div_zero;
            end

            if (w_done && r_pend_we) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end

            if (w_issue && (mdop == OP_MTHI)) begin
                r_hi <= inA;
            end
            if (w_issue && (mdop == OP_MTLO)) begin
                r_lo <= inA;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .inA   (inA),
        .inB   (inB),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench copy of the architectural HI/LO
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t scb[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] p;
        e.hi = m_hi;
        e.lo = m_lo;
        e.lat = 0;
        sa  = longint'(signed'(a));
        sbv = longint'(signed'(b));
        case (op)
            4'd1: begin
                p = 64'(sa * sbv);
                e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT;
            end
            4'd2: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT;
            end
            4'd3: begin
                e.lat = DIV_LAT;
                if (b != 0) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
            4'd4: begin
                e.lat = DIV_LAT;
                if (b != 0) begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            4'd5: e.hi = a;
            4'd6: e.lo = a;
`ifdef MDU_MSUB_EN
            4'd7: begin
                p = {m_hi, m_lo} - 64'(sa * sbv);
                e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT;
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    // Called at a falling edge; issues at the next rising edge and returns at
    // the falling edge of the first cycle with busy low.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, input string tag);
        exp_t e;
        int   n;
        scb.push_back(model(op, a, b));
        start = 1'b1; mdop = op; inA = a; inB = b;
        @(negedge clk);
        start = 1'b0; mdop = 4'd0; inA = $urandom; inB = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            check_eq({tag, "/hold"}, {HI, LO}, {m_hi, m_lo});
            n++;
            if (poke && n == 2) begin
                start = 1'b1; mdop = 4'd5; inA = 32'hDEADBEEF;
            end else begin
                start = 1'b0; mdop = 4'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; mdop = 4'd0;
        e = scb.pop_front();
        check_eq({tag, "/busy_cycles"}, 64'(n), 64'(e.lat));
        check_eq({tag, "/hilo"}, {HI, LO}, {e.hi, e.lo});
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    initial begin
        logic [3:0] rop;
        reset = 1'b1; start = 1'b0; mdop = 4'd0; inA = '0; inB = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_hilo", {HI, LO}, 64'd0);
        reset = 1'b0;

        // Issued on the first rising edge after reset release
        do_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, "mult");
        check_eq("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
        do_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1, "multu_poke");
        check_eq("multu_const", {HI, LO}, 64'h00000001_FFFFFFFE);
        do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div");
        check_eq("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        do_op(4'd4, 32'd7, 32'd0, 1'b0, "divu_by0");
        check_eq("divu_by0_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        check_eq("div_ovf_const", {HI, LO}, 64'h00000000_80000000);
        do_op(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, "div_negb");
        do_op(4'd3, 32'hFFFFFFF9, 32'd0, 1'b1, "div_by0");
        do_op(4'd5, 32'h12345678, 32'd0, 1'b0, "mthi");
        do_op(4'd6, 32'h00000009, 32'd0, 1'b0, "mtlo");
        check_eq("mthi_mtlo_const", {HI, LO}, 64'h12345678_00000009);
        do_op(4'd0, 32'h11111111, 32'h2, 1'b0, "none");
        do_op(4'd9, 32'h22222222, 32'h3, 1'b0, "undef");
        do_op(4'hF, 32'h33333333, 32'h4, 1'b0, "undef_f");

        // MSUB (a no-op when the feature is compiled out)
        do_op(4'd5, 32'd0, 32'd0, 1'b0, "msub_sethi");
        do_op(4'd6, 32'd10, 32'd0, 1'b0, "msub_setlo");
        do_op(4'd7, 32'd3, 32'd4, 1'b0, "msub");
`ifdef MDU_MSUB_EN
        check_eq("msub_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFE);
`else
        check_eq("msub_off_const", {HI, LO}, 64'h00000000_0000000A);
`endif

        for (int i = 0; i < 10; i++) begin
            rop = 4'($urandom_range(1, 4));
            do_op(rop, $urandom, (i == 3) ? 32'd0 : $urandom, 1'b0, "rand");
        end

        // Reset in the middle of a divide aborts it
        do_op(4'd5, 32'hA5A5A5A5, 32'd0, 1'b0, "pre_rst_hi");
        start = 1'b1; mdop = 4'd3; inA = 32'd100; inB = 32'd7;
        @(negedge clk);
        start = 1'b0; mdop = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("rst_async_busy", 64'(busy), 64'd0);
        check_eq("rst_async_hilo", {HI, LO}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("post_rst_idle", {31'd0, busy, HI, LO}, 64'd0);
        end
        do_op(4'd2, 32'd6, 32'd7, 1'b0, "post_rst_multu");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
